mealy_seq_counter: RTL

//  Mealy detector for the serial bit pattern 1011, with a mod-(MAX_COUNT+1) BCD counter of detections.

---
 rtl/mealy_seq_counter_pkg.sv | 33 +++
 rtl/mealy_seq_counter_if.sv | 20 ++
 rtl/mealy_seq_counter_bcd_counter.sv | 41 ++++
 rtl/mealy_seq_counter.sv | 53 +++++
 4 files changed

// File: rtl/mealy_seq_counter_pkg.sv
// mealy_seq_counter_pkg
//   Shared definitions for the 1011 detector and its BCD detection counter.
//   The downstream 7-segment decoder stage imports the same package, so the
//   state encoding and BCD limit are defined in one place.
//   Contents: state_t encoding, BCD_MAX, next-state helper.
package mealy_seq_counter_pkg;

  typedef enum logic [1:0] {
    S0   = 2'b00,
    S1   = 2'b01,
    S10  = 2'b10,
    S101 = 2'b11
  } state_t;

  localparam logic [3:0] BCD_MAX = 4'd9;

  // Next state for one valid bit. On a completed match the trailing 1 can
  // start the next pattern (overlap) or be discarded (restart from idle).
  function automatic state_t next_state(input state_t cur, input logic x,
                                        input bit overlap);
    state_t nxt;
    nxt = S0;
    unique case (cur)
      S0:   nxt = x ? S1   : S0;
      S1:   nxt = x ? S1   : S10;
      S10:  nxt = x ? S101 : S0;
      S101: nxt = x ? (overlap ? S1 : S0) : S10;
      default: nxt = S0;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/mealy_seq_counter_if.sv
// mealy_seq_counter_if
//   Serial-bit and result bundle between the bit sampler (master) and the
//   detector (slave).
//   en, x, clr   : master -> slave (bit strobe, data bit, counter clear)
//   det          : slave -> master, combinational Mealy detect
//   z[0:3]       : slave -> master, registered BCD count, z[0] = MSB
//   carry        : slave -> master, one-cycle wrap pulse
//   state[1:0]   : slave -> master, FSM state for debug/LEDs
interface mealy_seq_counter_if;
  logic       en;
  logic       x;
  logic       clr;
  logic       det;
  logic [0:3] z;
  logic       carry;
  logic [1:0] state;

  modport master (output en, x, clr, input det, z, carry, state);
  modport slave  (input en, x, clr, output det, z, carry, state);
endinterface

// File: rtl/mealy_seq_counter_bcd_counter.sv
// bcd_counter
//   Single BCD digit counting 0..MAX_COUNT and wrapping to 0. carry pulses
//   for one cycle on the wrap so digits can be chained carry -> inc.
//   clk, rst (sync, active high), inc, clr (sync clear, beats inc),
//   q[0:3] (q[0] = MSB), carry.
module bcd_counter
  import mealy_seq_counter_pkg::*;
#(
  parameter int MAX_COUNT = 9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic       clr,
  output logic [0:3] q,
  output logic       carry
);

  // Out-of-range settings fall back to a full decimal digit so q can never
  // reach a code the decoder would blank.
  localparam logic [3:0] LAST = (MAX_COUNT < 1 || MAX_COUNT > 9) ?
                                BCD_MAX : 4'(MAX_COUNT);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q     <= 4'd0;
      carry <= 1'b0;
    end else if (inc) begin
      if (q == LAST) begin
        q     <= 4'd0;
        carry <= 1'b1;
      end else begin
        q     <= q + 4'd1;
        carry <= 1'b0;
      end
    end else begin
      carry <= 1'b0;
    end
  end

endmodule

// File: rtl/mealy_seq_counter.sv
// mealy_seq_counter
//   Mealy detector for serial pattern 1011 feeding a BCD count of hits.
//   clk, rst (sync, active high) plain ports; everything else via bus
//   (mealy_seq_counter_if.slave): en, x, clr in; det, z[0:3], carry, state out.
//
//   state | meaning
//   ------+---------------------------------
//   S0    | idle, nothing matched
//   S1    | matched "1"
//   S10   | matched "10"
//   S101  | matched "101"; x=1 with en is a hit
module mealy_seq_counter
  import mealy_seq_counter_pkg::*;
#(
  parameter int MAX_COUNT = 9,
  parameter bit OVERLAP   = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  mealy_seq_counter_if.slave   bus
);

  state_t     state_q;
  logic       det_c;
  logic [0:3] z_q;
  logic       carry_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S0;
    end else if (bus.en) begin
      state_q <= next_state(state_q, bus.x, OVERLAP);
    end
  end

  // Unregistered on purpose: the count updates at the edge that samples it.
  assign det_c = (state_q == S101) && bus.en && bus.x;

  bcd_counter #(.MAX_COUNT(MAX_COUNT)) u_bcd_counter (
    .clk   (clk),
    .rst   (rst),
    .inc   (det_c),
    .clr   (bus.clr),
    .q     (z_q),
    .carry (carry_q)
  );

  assign bus.det   = det_c;
  assign bus.z     = z_q;
  assign bus.carry = carry_q;
  assign bus.state = state_q;

endmodule
